uart_tx_serializer: RTL and testbench

//  UART transmit stage directly downstream of the TX FIFO. Pops bytes with a one-cycle

---
 rtl/uart_tx_serializer.sv | 215 +++++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART TX serializer: pops bytes from the TX FIFO and shifts them out LSB-first.
// Optional parity bit (build macro UART_TX_PARITY_EN); frame 8N1/8N2 otherwise.
//
// Ports:
//   clk         system clock
//   rst_        synchronous active-low reset
//   tx_en       transmitter enable, sampled in IDLE and at end of STOP
//   baud_div    clk cycles per bit (0 treated as 1), latched in LOAD
//   stop2       1 = two stop bits, latched in LOAD
//   parity_en   parity bit enable, latched in LOAD (parity builds only)
//   parity_odd  1 = odd parity, 0 = even, latched in LOAD (parity builds only)
//   fifo_empty  TX FIFO empty flag
//   fifo_data   TX FIFO read data, valid the cycle after fifo_rinc
//   fifo_rinc   FIFO read strobe, one cycle per byte (FETCH only)
//   tx          serial line, idle high
//   busy        high in every state except IDLE
//   tx_done     one-cycle pulse in the last cycle of the last stop bit
module uart_tx_serializer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             tx_en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             stop2,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_data,
  output logic             fifo_rinc,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t           state_q;
  state_t           state_n;
  logic [DIV_W-1:0] baud_q;
  logic [DIV_W-1:0] baud_n;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_n;
  logic [DIV_W-1:0] div_eff;
  logic [2:0]       bit_q;
  logic [2:0]       bit_n;
  logic [7:0]       shift_q;
  logic [7:0]       shift_n;
  logic             stop2_q;
  logic             stop2_n;
  logic             par_q;
  logic             par_n;
  logic             par_en_q;
  logic             par_en_n;
  logic             bit_end;
  logic             more;
  logic             tx_n;
  logic             done_n;

`ifndef UART_TX_PARITY_EN
  logic unused_cfg;
  assign unused_cfg = parity_en ^ parity_odd;
`endif

  assign div_eff = (baud_div == '0) ? DIV_W'(1) : baud_div;
  assign bit_end = (baud_q == '0);
  assign more    = tx_en && !fifo_empty;

  always_comb begin
    state_n  = state_q;
    baud_n   = baud_q;
    div_n    = div_q;
    bit_n    = bit_q;
    shift_n  = shift_q;
    stop2_n  = stop2_q;
    par_n    = par_q;
    par_en_n = par_en_q;
    unique case (state_q)
      S_IDLE: begin
        if (more) state_n = S_FETCH;
      end
      S_FETCH: begin
        state_n = S_LOAD;
      end
      S_LOAD: begin
        shift_n = fifo_data;
        div_n   = div_eff;
        stop2_n = stop2;
`ifdef UART_TX_PARITY_EN
        par_en_n = parity_en;
        par_n    = ^fifo_data ^ parity_odd;
`else
        par_en_n = 1'b0;
        par_n    = 1'b0;
`endif
        baud_n  = div_eff - DIV_W'(1);
        bit_n   = 3'd0;
        state_n = S_START;
      end
      S_START: begin
        if (bit_end) begin
          baud_n  = div_q - DIV_W'(1);
          bit_n   = 3'd0;
          state_n = S_DATA;
        end else begin
          baud_n = baud_q - DIV_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_n  = div_q - DIV_W'(1);
          shift_n = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_n = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_n = par_en_q ? S_PARITY : S_STOP;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_n = bit_q + 3'd1;
          end
        end else begin
          baud_n = baud_q - DIV_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          baud_n  = div_q - DIV_W'(1);
          bit_n   = 3'd0;
          state_n = S_STOP;
        end else begin
          baud_n = baud_q - DIV_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == {2'b00, stop2_q}) begin
            bit_n   = 3'd0;
            baud_n  = '0;
            state_n = more ? S_FETCH : S_IDLE;
          end else begin
            bit_n  = bit_q + 3'd1;
            baud_n = div_q - DIV_W'(1);
          end
        end else begin
          baud_n = baud_q - DIV_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Outputs are computed from next-state values and registered,
  // so tx never glitches and all strobes line up with the state.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  assign done_n = (state_n == S_STOP) && (baud_n == '0) &&
                  (bit_n == {2'b00, stop2_n});

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      div_q     <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      stop2_q   <= 1'b0;
      par_q     <= 1'b0;
      par_en_q  <= 1'b0;
      tx        <= 1'b1;
      fifo_rinc <= 1'b0;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state_q   <= state_n;
      baud_q    <= baud_n;
      div_q     <= div_n;
      bit_q     <= bit_n;
      shift_q   <= shift_n;
      stop2_q   <= stop2_n;
      par_q     <= par_n;
      par_en_q  <= par_en_n;
      tx        <= tx_n;
      fifo_rinc <= (state_n == S_FETCH);
      busy      <= (state_n != S_IDLE);
      tx_done   <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: FIFO model, cycle trace vs frame-level model.
// Trace word per cycle is {tx, fifo_rinc, busy, tx_done}.
module tb_uart_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_;
  logic        tx_en;
  logic [15:0] baud_div;
  logic        stop2;
  logic        parity_en;
  logic        parity_odd;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rinc;
  logic        tx;
  logic        busy;
  logic        tx_done;

  always #5 clk = ~clk;

  uart_tx_serializer #(.DIV_W(16)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .tx_en      (tx_en),
    .baud_div   (baud_div),
    .stop2      (stop2),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rinc  (fifo_rinc),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  int         n_cmp = 0;
  int         n_fail = 0;
  int         viol = 0;
  int         n_push = 0;
  int         n_pop = 0;
  logic [7:0] mem [256];
  logic [3:0] trace [$];
  logic [3:0] exp_q [$];
  bit         rec = 1'b0;

  assign fifo_empty = (n_push == n_pop);

  always @(posedge clk) begin
    if (fifo_rinc) begin
      fifo_data <= mem[n_pop[7:0]];
      n_pop     <= n_pop + 1;
    end
  end

  always @(negedge clk) begin
    if (rec) trace.push_back({tx, fifo_rinc, busy, tx_done});
    if (fifo_rinc && fifo_empty) viol++;
  end

  task automatic push(input logic [7:0] b);
    mem[n_push[7:0]] = b;
    n_push++;
  endtask

  task automatic cap_start();
    trace.delete();
    exp_q.delete();
    rec = 1'b1;
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(4'b1000);
  endtask

  // One frame as seen from IDLE or from the previous stop bit:
  // FETCH cycle, LOAD cycle, then start/data/[parity]/stop bits.
  task automatic add_frame(input logic [7:0] b, input int div,
                           input bit s2, input bit pe, input bit po);
    int d;
    bit use_par;
    bit pbit;
    bit bits [$];
    d = (div < 1) ? 1 : div;
`ifdef UART_TX_PARITY_EN
    use_par = pe;
`else
    use_par = 1'b0;
`endif
    pbit = (($countones(b) % 2) == 1) ^ po;
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b1010);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (use_par) bits.push_back(pbit);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    for (int k = 0; k < bits.size(); k++)
      for (int c = 0; c < d; c++)
        exp_q.push_back({bits[k], 1'b0, 1'b1,
                         (k == bits.size() - 1) && (c == d - 1)});
  endtask

  task automatic wait_samples(input int n);
    for (int k = 0; k < n + 50; k++) begin
      if (trace.size() >= n) break;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag);
    logic [3:0] obs;
    wait_samples(exp_q.size());
    rec = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < trace.size()) ? trace[i] : 4'bxxxx;
      n_cmp++;
      assert (obs === exp_q[i]) else begin
        n_fail++;
        $error("FAIL %s[%0d] observed=%b expected=%b", tag, i, obs, exp_q[i]);
      end
    end
  endtask

  initial begin
    logic [7:0] b0;
    logic [7:0] b1;
    int         d;
    int         pops;
    int         nb;
    bit         s2;
    bit         pe;
    bit         po;
    logic [7:0] bl [$];

    rst_       = 1'b0;
    tx_en      = 1'b0;
    baud_div   = 16'd4;
    stop2      = 1'b0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    #1;

    // reset state
    cap_start();
    add_idle(3);
    check("reset");
    rst_ = 1'b1;

    // single 0xA5 frame, div 4, 8N1
    tx_en = 1'b1;
    cap_start();
    push(8'hA5);
    add_frame(8'hA5, 4, 1'b0, 1'b0, 1'b0);
    add_idle(3);
    check("a5_div4");

    // two back-to-back frames, div 2
    baud_div = 16'd2;
    cap_start();
    push(8'h01);
    push(8'h80);
    add_frame(8'h01, 2, 1'b0, 1'b0, 1'b0);
    add_frame(8'h80, 2, 1'b0, 1'b0, 1'b0);
    add_idle(3);
    check("b2b_div2");

    // empty FIFO, enabled: nothing happens
    pops = n_pop;
    cap_start();
    add_idle(100);
    check("empty");
    n_cmp++;
    assert (n_pop === pops) else begin
      n_fail++;
      $error("FAIL empty_pops observed=%0d expected=%0d", n_pop, pops);
    end

    // parity cases (no parity bit in builds without the feature)
    d = $urandom_range(2, 4);
    baud_div   = 16'(d);
    parity_en  = 1'b1;
    parity_odd = 1'b1;
    cap_start();
    push(8'h07);
    add_frame(8'h07, d, 1'b0, 1'b1, 1'b1);
    add_idle(2);
    check("par_odd");
    parity_odd = 1'b0;
    cap_start();
    push(8'h07);
    add_frame(8'h07, d, 1'b0, 1'b1, 1'b0);
    add_idle(2);
    check("par_even");
    stop2 = 1'b1;
    b0 = 8'($urandom);
    cap_start();
    push(b0);
    add_frame(b0, d, 1'b1, 1'b1, 1'b0);
    add_idle(2);
    check("par_stop2");
    stop2     = 1'b0;
    parity_en = 1'b0;

    // reset during data bit 3: byte lost, next byte follows release
    d  = $urandom_range(2, 5);
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    baud_div = 16'(d);
    cap_start();
    push(b0);
    push(b1);
    wait_samples(2 + 4 * d + 1);
    rst_ = 1'b0;
    trace.delete();
    exp_q.delete();
    add_idle(1);
    add_frame(b1, d, 1'b0, 1'b0, 1'b0);
    add_idle(3);
    @(negedge clk);
    #1;
    rst_ = 1'b1;
    check("rst_mid");

    // div 0 acts as 1; change to 8 mid-frame applies to next frame only
    baud_div = 16'd0;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    cap_start();
    push(b0);
    push(b1);
    add_frame(b0, 1, 1'b0, 1'b0, 1'b0);
    add_frame(b1, 8, 1'b0, 1'b0, 1'b0);
    add_idle(3);
    wait_samples(6);
    baud_div = 16'd8;
    check("div0_to8");

    // tx_en dropped mid-frame: frame completes, no further pop
    baud_div = 16'd3;
    b0 = 8'($urandom);
    pops = n_pop;
    cap_start();
    push(b0);
    push(8'($urandom));
    add_frame(b0, 3, 1'b0, 1'b0, 1'b0);
    add_idle(4);
    wait_samples(5);
    tx_en = 1'b0;
    check("en_drop");
    n_cmp++;
    assert (n_pop === pops + 1) else begin
      n_fail++;
      $error("FAIL en_drop_pops observed=%0d expected=%0d", n_pop, pops + 1);
    end
    n_push = n_pop;
    tx_en  = 1'b1;

    // randomized batches
    for (int t = 0; t < 6; t++) begin
      nb = $urandom_range(1, 3);
      d  = $urandom_range(0, 5);
      s2 = 1'($urandom);
      pe = 1'($urandom);
      po = 1'($urandom);
      baud_div   = 16'(d);
      stop2      = s2;
      parity_en  = pe;
      parity_odd = po;
      bl.delete();
      for (int i = 0; i < nb; i++) bl.push_back(8'($urandom));
      cap_start();
      foreach (bl[i]) push(bl[i]);
      foreach (bl[i]) add_frame(bl[i], d, s2, pe, po);
      add_idle(3);
      check($sformatf("rand%0d", t));
    end

    n_cmp++;
    assert (viol === 0) else begin
      n_fail++;
      $error("FAIL rinc_when_empty observed=%0d expected=0", viol);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
